// File: rtl/fft_sample_loader_if.sv
// Bundle between the serial sample source, the loader and the butterfly engine.
// The loader takes the slave side; the source/engine side uses master.
interface fft_sample_loader_if #(
    parameter int D_WIDTH     = 64,
    parameter int LOG_2_WIDTH = 6
);
    logic                        in_valid;
    logic                        in_ready;
    logic [15:0]                 in_re;
    logic [15:0]                 in_im;
    logic                        abort;
    logic                        fft_done;
    logic [D_WIDTH-1:0][15:0]    out_Re;
    logic [D_WIDTH-1:0][15:0]    out_Im;
    logic                        start;
    logic [LOG_2_WIDTH:0]        fill_count;
    logic [7:0]                  frames;

    modport master (
        output in_valid, in_re, in_im, abort, fft_done,
        input  in_ready, out_Re, out_Im, start, fill_count, frames
    );

    modport slave (
        input  in_valid, in_re, in_im, abort, fft_done,
        output in_ready, out_Re, out_Im, start, fill_count, frames
    );
endinterface

// File: rtl/fft_sample_loader.sv
// Collects D_WIDTH serial complex samples into a bit-reversed parallel frame,
// strobes start to the butterfly engine and waits for fft_done before refilling.
module fft_sample_loader #(
    parameter int D_WIDTH     = 64,
    parameter int LOG_2_WIDTH = 6
) (
    input  logic                clk,
    input  logic                rst,
    fft_sample_loader_if.slave  bus
);

    typedef enum logic [1:0] {
        FILL = 2'd0,
        FIRE = 2'd1,
        WAIT = 2'd2
    } state_e;

    localparam logic [LOG_2_WIDTH:0] LAST_IDX  = (LOG_2_WIDTH+1)'(D_WIDTH - 1);
    localparam logic [LOG_2_WIDTH:0] COUNT_ONE = (LOG_2_WIDTH+1)'(1);

    state_e                     state_q, state_d;
    logic [LOG_2_WIDTH:0]       fill_count_q, fill_count_d;
    logic [7:0]                 frames_q, frames_d;
    logic [D_WIDTH-1:0][15:0]   buf_re_q, buf_re_d;
    logic [D_WIDTH-1:0][15:0]   buf_im_q, buf_im_d;

    logic                       wr_en;
    logic [LOG_2_WIDTH-1:0]     wr_slot;

    function automatic logic [LOG_2_WIDTH-1:0] bitrev(input logic [LOG_2_WIDTH-1:0] k);
        logic [LOG_2_WIDTH-1:0] r;
        r = '0;
        for (int i = 0; i < LOG_2_WIDTH; i++) begin
            r[i] = k[LOG_2_WIDTH-1-i];
        end
        return r;
    endfunction

    // Slot of the next sample: the count of samples already taken, bit-reversed.
    assign wr_slot = bitrev(fill_count_q[LOG_2_WIDTH-1:0]);

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        state_d      = state_q;
        fill_count_d = fill_count_q;
        frames_d     = frames_q;
        wr_en        = 1'b0;

        unique case (state_q)
            FILL: begin
                if (bus.abort) begin
                    fill_count_d = '0;
                end else if (bus.in_valid) begin
                    wr_en        = 1'b1;
                    fill_count_d = fill_count_q + COUNT_ONE;
                    if (fill_count_q == LAST_IDX) begin
                        state_d = FIRE;
                    end
                end
            end
            FIRE: begin
                state_d  = WAIT;
                frames_d = frames_q + 8'd1;
            end
            WAIT: begin
                if (bus.fft_done) begin
                    state_d      = FILL;
                    fill_count_d = '0;
                end
            end
            default: begin
                state_d      = FILL;
                fill_count_d = '0;
            end
        endcase
    end

    // Untouched slots carry over from the previous frame; only the written slot changes.
    always_comb begin
        buf_re_d = buf_re_q;
        buf_im_d = buf_im_q;
        if (wr_en) begin
            buf_re_d[wr_slot] = bus.in_re;
            buf_im_d[wr_slot] = bus.in_im;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(negedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= FILL;
            fill_count_q <= '0;
            frames_q     <= '0;
        end else begin
            state_q      <= state_d;
            fill_count_q <= fill_count_d;
            frames_q     <= frames_d;
        end
    end

    // NOTE: the sample buffer is plain flops, not a RAM, because reset must clear every slot to zero.
    always_ff @(negedge clk or negedge rst) begin
        if (!rst) begin
            buf_re_q <= '0;
            buf_im_q <= '0;
        end else begin
            buf_re_q <= buf_re_d;
            buf_im_q <= buf_im_d;
        end
    end

    // Handshake and strobe decode straight from the state register.
    assign bus.in_ready   = (state_q == FILL);
    assign bus.start      = (state_q == FIRE);
    assign bus.fill_count = fill_count_q;
    assign bus.frames     = frames_q;
    assign bus.out_Re     = buf_re_q;
    assign bus.out_Im     = buf_im_q;

endmodule
